// File: rtl/l2_pkg.sv
// Shared widths and the arbiter state encoding for the L2 front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l2_pkg;

  localparam int L2_LINE_BITS = 512;
  localparam int PADDR_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above the pointer, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to act on the winner.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_winner
);

  logic [ID_W:0] w_idx;

  // Walk candidates from farthest to nearest so the nearest-to-pointer hit wins
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end
      if (i_req[w_idx[ID_W-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single-ported L2 between NUM_REQ requesters, one transaction in flight.
// Latency: grant to resp_done is 4 cycles minimum (L2 hit); TIMEOUT WAIT cycles bound a stuck L2.
// Backpressure: requesters hold req_valid until their resp_done; new grants only from IDLE.
module l2_arbiter
  import l2_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write_en,
  input  logic [NUM_REQ*PADDR_BITS-1:0]    req_paddr,
  input  logic [NUM_REQ*L2_LINE_BITS-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]               resp_done,
  output logic [L2_LINE_BITS-1:0]          resp_data,
  output logic                             resp_err,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             l2_request,
  output logic                             l2_write_en,
  output logic [PADDR_BITS-1:0]            l2_paddr,
  output logic [L2_LINE_BITS-1:0]          l2_write_data,
  input  logic [L2_LINE_BITS-1:0]          l2_data_out,
  input  logic                             l2_done
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_t               r_state;
  arb_state_t               w_next_state;
  logic [ID_W-1:0]          r_rr_ptr;
  logic [ID_W-1:0]          r_grant_id;
  logic [TMR_W-1:0]         r_timer;
  logic                     r_busy;
  logic                     r_l2_write_en;
  logic [PADDR_BITS-1:0]    r_l2_paddr;
  logic [L2_LINE_BITS-1:0]  r_l2_write_data;
  logic [L2_LINE_BITS-1:0]  r_resp_data;
  logic [NUM_REQ-1:0]       r_resp_done;
  logic                     r_resp_err;

  logic                     w_found;
  logic [ID_W-1:0]          w_winner;
  logic                     w_grant;
  logic                     w_complete;
  logic                     w_timeout;
  logic                     w_sel_we;
  logic [PADDR_BITS-1:0]    w_sel_paddr;
  logic [L2_LINE_BITS-1:0]  w_sel_wdata;
  logic [NUM_REQ-1:0]       w_done_vec;
  logic [ID_W-1:0]          w_rr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Select the winning requester's command fields from the packed buses
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_paddr = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_we    = req_write_en[i];
        w_sel_paddr = req_paddr[i*PADDR_BITS +: PADDR_BITS];
        w_sel_wdata = req_wdata[i*L2_LINE_BITS +: L2_LINE_BITS];
      end
    end
  end

  // One-hot completion vector for the current owner
  always_comb begin
    w_done_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_done_vec[i] = (r_grant_id == ID_W'(i));
    end
  end

  assign w_rr_next = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and transaction events; HOLD deliberately ignores the stale l2_done level
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant      = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: w_next_state = HOLD;
      HOLD:  w_next_state = WAIT;
      WAIT: begin
        if (l2_done) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Command/response registers, WAIT timer and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr        <= '0;
      r_grant_id      <= '0;
      r_timer         <= '0;
      r_busy          <= 1'b0;
      r_l2_write_en   <= 1'b0;
      r_l2_paddr      <= '0;
      r_l2_write_data <= '0;
      r_resp_data     <= '0;
      r_resp_done     <= '0;
      r_resp_err      <= 1'b0;
    end else begin
      r_resp_done <= '0;
      r_resp_err  <= 1'b0;
      if (w_grant) begin
        r_grant_id      <= w_winner;
        r_busy          <= 1'b1;
        r_l2_write_en   <= w_sel_we;
        r_l2_paddr      <= w_sel_paddr;
        r_l2_write_data <= w_sel_wdata;
      end
      if (r_state == HOLD) begin
        r_timer <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_complete) begin
        r_resp_data <= l2_data_out;
      end
      if (w_complete || w_timeout) begin
        r_resp_done <= w_done_vec;
        r_resp_err  <= w_timeout;
        r_busy      <= 1'b0;
        r_rr_ptr    <= w_rr_next;
      end
    end
  end

  assign l2_request    = (r_state == ISSUE);
  assign l2_write_en   = r_l2_write_en;
  assign l2_paddr      = r_l2_paddr;
  assign l2_write_data = r_l2_write_data;
  assign resp_done     = r_resp_done;
  assign resp_data     = r_resp_data;
  assign resp_err      = r_resp_err;
  assign busy          = r_busy;
  assign grant_id      = r_grant_id;

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Round-robin arbiter that shares the single-ported L2 cache between NUM_REQ upstream requesters (L1I, L1D, page walker).
- Accepts at most one transaction at a time and registers the winner's command.
- Drives the L2 request/write_en/paddr/write_data inputs and returns data_out plus a one-cycle done pulse to the winner.
- Sits between the L1 controllers and l2_cache; has no data storage of its own beyond the command and response registers.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..4)
- ID_W, 1, width of the requester index; must equal ceil(log2(NUM_REQ)), minimum 1
- TIMEOUT, 1024, WAIT cycles before the transaction is abandoned

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request level; held until that requester's resp_done
- req_write_en  in  NUM_REQ  per-requester write flag
- req_paddr  in  NUM_REQ*32  packed physical addresses; requester i at [i*32 +: 32]
- req_wdata  in  NUM_REQ*512  packed 64-byte write lines; requester i at [i*512 +: 512]
- resp_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- resp_data  out  512  read line; valid only while a resp_done bit is high
- resp_err  out  1  one-cycle pulse alongside resp_done when the transaction timed out
- busy  out  1  high from grant through completion
- grant_id  out  ID_W  index of the current or last winner
- l2_request  out  1  one-cycle request pulse to L2
- l2_write_en  out  1  registered write flag
- l2_paddr  out  32  registered address
- l2_write_data  out  512  registered write line
- l2_data_out  in  512  L2 read data
- l2_done  in  1  L2 done level

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE.
  - All outputs 0, including the l2_* command registers and resp_data.
  - rr_ptr=0, timer=0.
  - A reset during ISSUE, HOLD or WAIT abandons the transaction with no resp_done.
- States: IDLE -> ISSUE -> HOLD -> WAIT -> IDLE.
- IDLE:
  - If any req_valid bit is high, pick the first set bit searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - Latch that requester's write_en, paddr and wdata into the l2_* registers.
  - Set grant_id, set busy=1, go to ISSUE.
  - If no req_valid bit is high, stay in IDLE.
- ISSUE: l2_request=1 for exactly this one cycle; go to HOLD.
- HOLD:
  - One cycle, l2_request=0.
  - l2_done is ignored in this cycle because L2 spends it in its CHECK state and the level is stale; go to WAIT.
- WAIT:
  - When l2_done=1, capture l2_data_out into resp_data.
  - In the next cycle: pulse resp_done[grant_id]=1, set busy=0, rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
  - Minimum latency, grant to resp_done: 4 cycles (L2 hit).
- Timeout:
  - timer counts WAIT cycles.
  - When timer==TIMEOUT-1 and l2_done=0, pulse resp_done[grant_id] and resp_err together, leave resp_data unchanged, go to IDLE.
  - timer clears on entry to WAIT.
- Commands are always registered, so upstream changes to req_* after grant have no effect on the transaction in flight.
- resp_data holds its value after resp_done deasserts.
- Simultaneous requests: round-robin, never fixed priority.
  - Example: with NUM_REQ=2 and both requesters continuously valid, grants alternate 0,1,0,1.
- A requester whose req_valid is still high in the cycle after its own resp_done may be granted again, but only if no other requester is valid.
- req_valid dropping before grant: no grant is issued for that requester.
- req_valid dropping after grant: the transaction still completes and resp_done still pulses.
- rr_ptr wrap-around: NUM_REQ-1 + 1 wraps to 0.
- rr_ptr values >= NUM_REQ are unreachable.

Decomposition:
- Shared package l2_pkg holds:
  - L2_LINE_BITS=512, PADDR_BITS=32
  - arb_state_t enum {IDLE, ISSUE, HOLD, WAIT}
- One sub-module rr_picker: combinational round-robin search.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, winner index.
  - Verified standalone.

Test Plan:
- Single read: req_valid=01, paddr=0x0000_1040, L2 asserts done with data 0xA5..A5 in cycle 3 -> l2_request pulses exactly once; resp_done=01 in cycle 4 with resp_data=0xA5..A5.
- Write: requester 1, write_en=1, wdata=0x1234..., paddr=0x0000_2000 -> l2_write_en=1, l2_paddr=0x0000_2000, l2_write_data matches wdata, resp_done=10.
- Contention: req_valid=11 held for 4 transactions -> grant_id sequence 0,1,0,1; each resp_done one-hot, one cycle wide.
- Stale done: l2_done held at 1 from the previous transaction through ISSUE and HOLD, then cleared for 20 cycles (miss), then set -> resp_done only after the new l2_done.
- Timeout: TIMEOUT=16, l2_done stuck at 0 -> resp_done and resp_err pulse together 16 WAIT cycles after entry; arbiter returns to IDLE.
- Reset in WAIT: reset_n low for 1 cycle mid-transaction -> all outputs 0 immediately; no resp_done; a new request after reset is accepted from rr_ptr=0.
